// File: rtl/l2_burst_memory_if.sv
// Request/data bus between the L1 controller (master) and the L2 burst memory (slave).
// One transaction moves an aligned 8-word block in eight consecutive data beats.
interface l2_burst_memory_if;
  logic        read_l2;
  logic        write_l2;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        l2_ack;
  logic [31:0] rdata;
  logic [2:0]  beat;
  logic        busy;
  logic        done;

  modport master (
    output read_l2, write_l2, addr, wdata,
    input  l2_ack, rdata, beat, busy, done
  );

  modport slave (
    input  read_l2, write_l2, addr, wdata,
    output l2_ack, rdata, beat, busy, done
  );
endinterface

// File: rtl/l2_burst_memory.sv
// L2 burst memory: fixed-latency 8-beat block reads (allocate) and writes (write-back).
// Write-back wins over allocate when both are requested in the same idle cycle.
module l2_burst_memory #(
  parameter int unsigned LATENCY     = 4,
  parameter int unsigned DEPTH_WORDS = 1024
) (
  input logic              clk,
  input logic              reset,
  l2_burst_memory_if.slave bus
);
  localparam int unsigned AW      = $clog2(DEPTH_WORDS);
  localparam logic [3:0]  LatLast = 4'(LATENCY - 1);

  typedef enum logic [2:0] {StIdle, StWait, StRdBurst, StWrBurst, StDone} state_e;

  state_e        state_q, state_d;
  logic [3:0]    lat_q, lat_d;
  logic [2:0]    beat_q, beat_d;
  // Block number; the word index is {blk, beat}, so a burst never leaves its block.
  logic [AW-4:0] blk_q, blk_d;
  logic          wr_q, wr_d;
  logic [AW-1:0] word_idx;
  logic          in_burst;
  logic [31:0]   mem [DEPTH_WORDS];
  logic          unused_addr;

  assign unused_addr = ^bus.addr;
  assign word_idx    = {blk_q, beat_q};
  assign in_burst    = (state_q == StRdBurst) || (state_q == StWrBurst);

  always_comb begin
    state_d = state_q;
    lat_d   = lat_q;
    beat_d  = beat_q;
    blk_d   = blk_q;
    wr_d    = wr_q;
    unique case (state_q)
      StIdle: begin
        if (bus.write_l2 || bus.read_l2) begin
          state_d = StWait;
          lat_d   = '0;
          blk_d   = bus.addr[AW+1:5];
          wr_d    = bus.write_l2;
        end
      end
      StWait: begin
        if (lat_q == LatLast) begin
          state_d = wr_q ? StWrBurst : StRdBurst;
          lat_d   = '0;
        end else begin
          lat_d = lat_q + 4'd1;
        end
      end
      StRdBurst, StWrBurst: begin
        beat_d = beat_q + 3'd1;
        if (beat_q == 3'd7) begin
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      lat_q   <= '0;
      beat_q  <= '0;
      blk_q   <= '0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      lat_q   <= lat_d;
      beat_q  <= beat_d;
      blk_q   <= blk_d;
      wr_q    <= wr_d;
    end
  end

  // Memory is never cleared; reset only blocks the write of the current beat.
  always_ff @(posedge clk) begin
    if (!reset && (state_q == StWrBurst)) begin
      mem[word_idx] <= bus.wdata;
    end
  end

  always_comb begin
    bus.l2_ack = in_burst;
    bus.rdata  = (state_q == StRdBurst) ? mem[word_idx] : '0;
    bus.beat   = in_burst ? beat_q : 3'd0;
    bus.busy   = (state_q != StIdle);
    bus.done   = (state_q == StDone);
  end
endmodule

// File: tb/tb_l2_burst_memory.sv
// Randomized self-checking bench for l2_burst_memory against a block-level memory model.
module tb_l2_burst_memory;
  localparam int unsigned LAT   = 4;
  localparam int unsigned DEPTH = 1024;

  logic clk;
  logic reset;
  l2_burst_memory_if bus ();

  l2_burst_memory #(
    .LATENCY    (LAT),
    .DEPTH_WORDS(DEPTH)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  logic [31:0] model_mem [DEPTH];
  logic [31:0] wbuf [8];
  int n_checks;
  int n_errors;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_busy"}, 32'(bus.busy), 32'd0);
    check({tag, "_ack"}, 32'(bus.l2_ack), 32'd0);
    check({tag, "_done"}, 32'(bus.done), 32'd0);
    check({tag, "_rdata"}, bus.rdata, 32'd0);
    check({tag, "_beat"}, 32'(bus.beat), 32'd0);
  endtask

  // One complete transaction as seen from the L1 side. abort_at >= 0 asserts reset
  // during that write beat. hold=0 drops the request (and scrambles addr) after capture.
  task automatic run_txn(input bit wr, input bit rd, input logic [31:0] a, input bit hold,
                         input int abort_at);
    int unsigned base;
    bit is_wr;
    is_wr = wr;
    base  = ((a >> 2) % DEPTH) & ~32'd7;
    @(negedge clk);
    check("idle_busy", 32'(bus.busy), 32'd0);
    check("idle_ack", 32'(bus.l2_ack), 32'd0);
    bus.read_l2  = rd;
    bus.write_l2 = wr;
    bus.addr     = a;
    bus.wdata    = $urandom;
    for (int t = 1; t <= int'(LAT) + 9; t++) begin
      @(negedge clk);
      if (t == 1 && !hold) begin
        bus.read_l2  = 1'b0;
        bus.write_l2 = 1'b0;
        bus.addr     = $urandom;
      end
      if (t <= int'(LAT)) begin
        check("wait_ack", 32'(bus.l2_ack), 32'd0);
        check("wait_busy", 32'(bus.busy), 32'd1);
        check("wait_rdata", bus.rdata, 32'd0);
      end else if (t <= int'(LAT) + 8) begin
        int i;
        i = t - int'(LAT) - 1;
        check("burst_ack", 32'(bus.l2_ack), 32'd1);
        check("burst_beat", 32'(bus.beat), 32'(i));
        check("burst_busy", 32'(bus.busy), 32'd1);
        check("burst_done", 32'(bus.done), 32'd0);
        check("burst_rdata", bus.rdata, is_wr ? 32'd0 : model_mem[base + 32'(i)]);
        if (is_wr) begin
          bus.wdata = wbuf[i];
          if (i == abort_at) begin
            reset = 1'b1;
            @(negedge clk);
            check_quiet("abort");
            reset        = 1'b0;
            bus.read_l2  = 1'b0;
            bus.write_l2 = 1'b0;
            for (int j = 0; j < i; j++) model_mem[base + 32'(j)] = wbuf[j];
            return;
          end
        end
      end else begin
        check("done_pulse", 32'(bus.done), 32'd1);
        check("done_ack", 32'(bus.l2_ack), 32'd0);
        check("done_busy", 32'(bus.busy), 32'd1);
        check("done_rdata", bus.rdata, 32'd0);
        check("done_beat", 32'(bus.beat), 32'd0);
      end
    end
    bus.read_l2  = 1'b0;
    bus.write_l2 = 1'b0;
    if (is_wr) begin
      for (int j = 0; j < 8; j++) model_mem[base + 32'(j)] = wbuf[j];
    end
  endtask

  initial begin
    n_checks     = 0;
    n_errors     = 0;
    reset        = 1'b1;
    bus.read_l2  = 1'b0;
    bus.write_l2 = 1'b0;
    bus.addr     = '0;
    bus.wdata    = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_quiet("reset");
    reset = 1'b0;

    // Give every word a known value.
    for (int b = 0; b < int'(DEPTH / 8); b++) begin
      for (int j = 0; j < 8; j++) wbuf[j] = $urandom;
      run_txn(1'b1, 1'b0, 32'(b * 32), 1'b1, -1);
    end

    // Write then read back at 0x40.
    for (int j = 0; j < 8; j++) wbuf[j] = 32'h100 + 32'(j);
    run_txn(1'b1, 1'b0, 32'h40, 1'b1, -1);
    run_txn(1'b0, 1'b1, 32'h40, 1'b1, -1);

    // Simultaneous read and write: the write wins.
    for (int j = 0; j < 8; j++) wbuf[j] = $urandom;
    run_txn(1'b1, 1'b1, 32'h80, 1'b1, -1);
    run_txn(1'b0, 1'b1, 32'h80, 1'b0, -1);

    // Unaligned address and wrap-around.
    run_txn(1'b0, 1'b1, 32'h5C, 1'b1, -1);
    run_txn(1'b0, 1'b1, 32'h1000, 1'b1, -1);
    run_txn(1'b0, 1'b1, 32'h0, 1'b0, -1);

    // Reset during beat 3 of a write, then read the partially written block.
    for (int j = 0; j < 8; j++) wbuf[j] = 32'hA000_0000 | 32'(j);
    run_txn(1'b1, 1'b0, 32'h200, 1'b1, 3);
    run_txn(1'b0, 1'b1, 32'h200, 1'b1, -1);

    // One-cycle request pulse still yields a full transaction.
    run_txn(1'b0, 1'b1, 32'h3FC, 1'b0, -1);

    // Reset beats a request sampled in the same cycle.
    @(negedge clk);
    bus.read_l2 = 1'b1;
    bus.addr    = 32'h40;
    reset       = 1'b1;
    @(negedge clk);
    check_quiet("rst_prio");
    reset       = 1'b0;
    bus.read_l2 = 1'b0;
    @(negedge clk);
    check_quiet("rst_prio_after");

    for (int n = 0; n < 40; n++) begin
      int op;
      op = int'($urandom_range(0, 2));
      for (int j = 0; j < 8; j++) wbuf[j] = $urandom;
      run_txn(op != 0, op != 1, $urandom, 1'($urandom), -1);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/l2_burst_memory.md
L2_BURST_MEMORY -- requirements
Module: l2_burst_memory

Interface
REQ-001 SHALL have parameter LATENCY, default 4: idle cycles between request capture and first data beat, legal range 1..15.
REQ-002 SHALL have parameter DEPTH_WORDS, default 1024: number of 32-bit words, power of two, at least 8.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on posedge clk.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port read_l2, input, 1 bit: block-read (allocate) request level from the L1 controller.
REQ-006 SHALL have port write_l2, input, 1 bit: block-write (write-back) request level from the L1 controller.
REQ-007 SHALL have port addr, input, 32 bits: byte address of the requested block.
REQ-008 SHALL have port wdata, input, 32 bits: write-back data word, sampled on each write beat.
REQ-009 SHALL have port l2_ack, output, 1 bit: data-beat strobe, high for exactly 8 consecutive cycles per transaction.
REQ-010 SHALL have port rdata, output, 32 bits: read data word, valid while l2_ack is high during a read.
REQ-011 SHALL have port beat, output, 3 bits: index of the current beat, 0..7.
REQ-012 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-013 SHALL have port done, output, 1 bit: one-cycle pulse in the cycle after the last beat.

Function
REQ-014 SHALL implement an FSM with states IDLE, WAIT, RD_BURST, WR_BURST and DONE.
REQ-015 SHALL, in IDLE with read_l2 or write_l2 high, capture base = addr[31:2] with bits [2:0] cleared, taken modulo DEPTH_WORDS, plus the operation type, then enter WAIT.
REQ-016 SHALL give write_l2 priority when write_l2 and read_l2 are both high in IDLE, so that write-back precedes allocate.
REQ-017 SHALL remain in WAIT for exactly LATENCY cycles with l2_ack=0, then enter RD_BURST or WR_BURST.
REQ-018 SHALL, in RD_BURST, drive l2_ack=1 and rdata=mem[base+beat] in the same cycle, with beat incrementing 0..7 on successive cycles.
REQ-019 SHALL, in WR_BURST, drive l2_ack=1 and write mem[base+beat] <= wdata at each posedge, with beat incrementing 0..7.
REQ-020 SHALL compute word index base+beat modulo DEPTH_WORDS; the 8 words of a block are contiguous and never cross a block boundary.
REQ-021 SHALL leave the burst state after beat 7 and hold DONE for exactly one cycle (done=1, l2_ack=0, busy=1), then return to IDLE.
REQ-022 SHALL make request capture in IDLE one cycle after DONE at the earliest, so back-to-back transactions are separated by one IDLE cycle.
REQ-023 SHALL ignore read_l2, write_l2 and addr changes outside IDLE; a request deasserted mid-transaction does not abort it.
REQ-024 SHALL give each transaction a fixed duration of 1 (IDLE capture) + LATENCY + 8 + 1 (DONE) cycles from request to return to IDLE.
REQ-025 SHALL drive rdata=0 whenever it is not in RD_BURST.
REQ-026 SHALL drive beat=0 whenever it is not in a burst state.

Reset
REQ-027 SHALL, on reset=1 at posedge clk, go to IDLE and clear the latency counter and beat, so that l2_ack=0, rdata=0, beat=0, busy=0 and done=0.
REQ-028 SHALL apply REQ-027 from any state when reset is asserted mid-transaction; an interrupted write keeps the words already written and writes none of the remaining ones.
REQ-029 SHALL NOT clear memory contents on reset.
REQ-030 SHALL give reset priority over a request sampled in the same cycle.

Verification
REQ-031 SHALL cover write then read: write_l2 at addr 0x40 with wdata 0x100..0x107, then read_l2 at 0x40 -> rdata 0x100..0x107 on beats 0..7, first beat 1+LATENCY cycles after capture.
REQ-032 SHALL cover simultaneous requests: read_l2=1 and write_l2=1 in IDLE -> WR_BURST taken, memory updated, no rdata driven.
REQ-033 SHALL cover unaligned address: read_l2 at 0x5C -> beats return words at byte addresses 0x40..0x5C, beat 0 = word 0x40.
REQ-034 SHALL cover wrap-around: with DEPTH_WORDS=1024, read at byte address 0x1000 -> same data as address 0x0.
REQ-035 SHALL cover reset mid-write: reset asserted at beat 3 -> next cycle busy=0 and l2_ack=0; a later read shows words 0..2 new and words 3..7 old.
REQ-036 SHALL cover request dropped mid-transaction: read_l2 held high one cycle only -> still exactly 8 l2_ack cycles followed by one done pulse.
